// File: rtl/gpi_irq_ctrl.sv
// GPI interrupt controller: synchronized input lines, rise/fall edge capture into a W1C
// pending register, registered level interrupt. Define GPI_IRQ_DEBOUNCE_EN for per-line debounce.
module gpi_irq_ctrl #(
  parameter int          N    = 32,
  parameter logic [31:0] BASE = 32'h0,
  parameter int          DB_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] gpi_data,
  input  logic         i_rd,
  input  logic [31:0]  i_addr,
  input  logic         i_wr,
  input  logic [3:0]   i_wrmask,
  input  logic [31:0]  i_data,
  output logic         o_rd_valid,
  output logic         o_wr_valid,
  output logic [31:0]  o_data,
  output logic         o_irq
);

  localparam logic [2:0] R_LEVEL = 3'd0;
  localparam logic [2:0] R_RISE  = 3'd1;
  localparam logic [2:0] R_FALL  = 3'd2;
  localparam logic [2:0] R_PEND  = 3'd3;
  localparam logic [2:0] R_IRQEN = 3'd4;
  localparam logic [2:0] R_DB    = 3'd5;

  function automatic logic [N-1:0] merge_n(input logic [N-1:0] old, input logic [31:0] data,
                                           input logic [31:0] m);
    logic [31:0] w;
    w = '0;
    w[N-1:0] = old;
    w = (w & ~m) | (data & m);
    return w[N-1:0];
  endfunction

  function automatic logic [31:0] widen_n(input logic [N-1:0] v);
    logic [31:0] w;
    w = '0;
    w[N-1:0] = v;
    return w;
  endfunction

  logic [N-1:0] sync1_q, sync2_q;
  logic [N-1:0] lvl_q, lvl_d, lvl_prev_q, lvl_prev_d;
  logic [N-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [N-1:0] pending_q, pending_d, irq_en_q, irq_en_d;
  logic [N-1:0] edge_ev, w1c;
  logic [1:0]   settle_q, settle_d;
  logic         settled;
  logic         irq_q, irq_d;
  logic [31:0]  off, wmask, rdata, db_rdata;
  logic [2:0]   idx;
  logic         sel, wr_hit;

  // Until the synchronizer and lvl hold real samples, lvl and its history load together
  // so nothing captured from reset values can look like an edge.
  assign settled = (settle_q == 2'd3);

  always_comb begin
    off        = i_addr - BASE;
    idx        = off[4:2];
    sel        = (off[31:5] == 27'd0) && (off[1:0] == 2'b00) && (idx <= R_DB);
    wmask      = {{8{i_wrmask[3]}}, {8{i_wrmask[2]}}, {8{i_wrmask[1]}}, {8{i_wrmask[0]}}};
    o_rd_valid = i_rd & sel;
    o_wr_valid = i_wr & sel & (idx != R_LEVEL);
    wr_hit     = o_wr_valid;
    rdata      = '0;
    case (idx)
      R_LEVEL: rdata = widen_n(lvl_q);
      R_RISE:  rdata = widen_n(rise_en_q);
      R_FALL:  rdata = widen_n(fall_en_q);
      R_PEND:  rdata = widen_n(pending_q);
      R_IRQEN: rdata = widen_n(irq_en_q);
      R_DB:    rdata = db_rdata;
      default: rdata = '0;
    endcase
    o_data = o_rd_valid ? rdata : '0;
  end

  always_comb begin
    settle_d   = settled ? settle_q : settle_q + 2'd1;
    lvl_prev_d = settled ? lvl_q : lvl_d;
    edge_ev    = (lvl_q & ~lvl_prev_q & rise_en_q) | (~lvl_q & lvl_prev_q & fall_en_q);
    w1c        = (wr_hit && idx == R_PEND) ? merge_n('0, i_data, wmask) : '0;
    // A new event wins over a simultaneous clear of the same bit.
    pending_d  = (pending_q & ~w1c) | edge_ev;
    irq_d      = |(pending_q & irq_en_q);
    rise_en_d  = (wr_hit && idx == R_RISE)  ? merge_n(rise_en_q, i_data, wmask) : rise_en_q;
    fall_en_d  = (wr_hit && idx == R_FALL)  ? merge_n(fall_en_q, i_data, wmask) : fall_en_q;
    irq_en_d   = (wr_hit && idx == R_IRQEN) ? merge_n(irq_en_q, i_data, wmask)  : irq_en_q;
  end

`ifdef GPI_IRQ_DEBOUNCE_EN
  function automatic logic [DB_W-1:0] merge_db(input logic [DB_W-1:0] old, input logic [31:0] data,
                                               input logic [31:0] m);
    logic [31:0] w;
    w = '0;
    w[DB_W-1:0] = old;
    w = (w & ~m) | (data & m);
    return w[DB_W-1:0];
  endfunction

  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [DB_W-1:0] cnt_q [N];
  logic [DB_W-1:0] cnt_d [N];

  // lvl follows sync only after DB_CNT+1 consecutive differing samples.
  always_comb begin
    db_cnt_d = (wr_hit && idx == R_DB) ? merge_db(db_cnt_q, i_data, wmask) : db_cnt_q;
    db_rdata = '0;
    db_rdata[DB_W-1:0] = db_cnt_q;
    lvl_d = lvl_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (!settled) begin
        lvl_d[i] = sync2_q[i];
      end else if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] >= db_cnt_q) lvl_d[i] = sync2_q[i];
        else                      cnt_d[i] = cnt_q[i] + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt_q <= '0;
      cnt_q    <= '{default: '0};
    end else begin
      db_cnt_q <= db_cnt_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  assign lvl_d    = sync2_q;
  assign db_rdata = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      pending_q  <= '0;
      irq_en_q   <= '0;
      settle_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= gpi_data;
      sync2_q    <= sync1_q;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_prev_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      pending_q  <= pending_d;
      irq_en_q   <= irq_en_d;
      settle_q   <= settle_d;
      irq_q      <= irq_d;
    end
  end

  assign o_irq = irq_q;

endmodule

// File: tb/tb_gpi_irq_ctrl.sv
// Self-checking bench for gpi_irq_ctrl; expected values queued at stimulus time, popped at observation.
`timescale 1ns/1ps
module tb_gpi_irq_ctrl;
  localparam int          N    = 32;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          DB_W = 8;
  localparam logic [31:0] A_LEVEL = BASE;
  localparam logic [31:0] A_RISE  = BASE + 32'h04;
  localparam logic [31:0] A_FALL  = BASE + 32'h08;
  localparam logic [31:0] A_PEND  = BASE + 32'h0C;
  localparam logic [31:0] A_IRQEN = BASE + 32'h10;
  localparam logic [31:0] A_DB    = BASE + 32'h14;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] gpi_data = '0;
  logic         i_rd = 1'b0;
  logic [31:0]  i_addr = '0;
  logic         i_wr = 1'b0;
  logic [3:0]   i_wrmask = '0;
  logic [31:0]  i_data = '0;
  logic         o_rd_valid, o_wr_valid, o_irq;
  logic [31:0]  o_data;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q [$];

  always #10 clk = ~clk;

  gpi_irq_ctrl #(.N(N), .BASE(BASE), .DB_W(DB_W)) dut (
    .clk(clk), .rst(rst), .gpi_data(gpi_data),
    .i_rd(i_rd), .i_addr(i_addr), .i_wr(i_wr), .i_wrmask(i_wrmask), .i_data(i_data),
    .o_rd_valid(o_rd_valid), .o_wr_valid(o_wr_valid), .o_data(o_data), .o_irq(o_irq)
  );

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic v);
    i_rd = 1'b1; i_addr = a;
    #1;
    d = o_data; v = o_rd_valid;
    i_rd = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                    input logic with_rd, output logic v, output logic [31:0] pre);
    @(negedge clk);
    i_wr = 1'b1; i_rd = with_rd; i_addr = a; i_data = d; i_wrmask = m;
    #1;
    v = o_wr_valid; pre = o_data;
    @(posedge clk); #1;
    i_wr = 1'b0; i_rd = 1'b0; i_wrmask = 4'h0;
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    logic v;
    rst = 1'b0; gpi_data = '1;
    repeat (2) @(negedge clk);
    exp_q.push_back(32'd0);
    for (int k = 0; k < 6; k++) exp_q.push_back(32'd0);
    e = exp_q.pop_front(); checks++;
    if (o_irq !== e[0]) begin failures++; $display("FAIL reset_irq got=%b want=%b", o_irq, e[0]); end
    for (int k = 0; k < 6; k++) begin
      rd(BASE + 32'(4 * k), d, v);
      e = exp_q.pop_front(); checks++;
      if (d !== e || v !== 1'b1) begin
        failures++; $display("FAIL reset_reg%0d got=%h/%b want=%h/1", k, d, v, e);
      end
    end
    @(negedge clk); #2 rst = 1'b1;
    repeat (6) @(negedge clk);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0);
    rd(A_LEVEL, d, v);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL release_level got=%h want=%h", d, e); end
    rd(A_PEND, d, v);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL release_pending got=%h want=%h", d, e); end
    gpi_data = '0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_rw_regs();
    logic [31:0] d, pre, e;
    logic v, wv;
    wr(A_RISE, 32'hFFFF_FFFF, 4'hF, 1'b0, wv, pre);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'hFF00_FF00);
    wr(A_RISE, 32'h0000_0000, 4'b0101, 1'b1, wv, pre);
    e = exp_q.pop_front(); checks++;
    if (wv !== e[0]) begin failures++; $display("FAIL rise_en_wr_valid got=%b want=%b", wv, e[0]); end
    e = exp_q.pop_front(); checks++;
    if (pre !== e) begin failures++; $display("FAIL rd_during_wr got=%h want=%h", pre, e); end
    rd(A_RISE, d, v);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL rise_en_bytemask got=%h want=%h", d, e); end
    wr(A_IRQEN, 32'h1234_5678, 4'b1010, 1'b0, wv, pre);
    exp_q.push_back(32'h1200_5600);
    rd(A_IRQEN, d, v);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL irq_en_bytemask got=%h want=%h", d, e); end
    wr(A_DB, 32'h1234_56AB, 4'hF, 1'b0, wv, pre);
    exp_q.push_back(32'd1);
`ifdef GPI_IRQ_DEBOUNCE_EN
    exp_q.push_back(32'h0000_00AB);
`else
    exp_q.push_back(32'h0);
`endif
    e = exp_q.pop_front(); checks++;
    if (wv !== e[0]) begin failures++; $display("FAIL db_cnt_wr_valid got=%b want=%b", wv, e[0]); end
    rd(A_DB, d, v);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL db_cnt_read got=%h want=%h", d, e); end
    wr(A_RISE, 32'h0, 4'hF, 1'b0, wv, pre);
    wr(A_IRQEN, 32'h0, 4'hF, 1'b0, wv, pre);
    wr(A_DB, 32'h0, 4'hF, 1'b0, wv, pre);
  endtask

  task automatic test_rise_irq();
    logic [31:0] d, e;
    logic v, wv;
    logic [31:0] pre;
    wr(A_RISE, 32'h8, 4'hF, 1'b0, wv, pre);
    wr(A_IRQEN, 32'h8, 4'hF, 1'b0, wv, pre);
    @(negedge clk);
    gpi_data[3] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      exp_q.push_back((c >= 3) ? 32'h8 : 32'h0);
      exp_q.push_back((c >= 4) ? 32'h8 : 32'h0);
      exp_q.push_back((c >= 5) ? 32'd1 : 32'd0);
    end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      rd(A_LEVEL, d, v);
      e = exp_q.pop_front(); checks++;
      if (d !== e) begin failures++; $display("FAIL rise_level_c%0d got=%h want=%h", c, d, e); end
      rd(A_PEND, d, v);
      e = exp_q.pop_front(); checks++;
      if (d !== e) begin failures++; $display("FAIL rise_pending_c%0d got=%h want=%h", c, d, e); end
      e = exp_q.pop_front(); checks++;
      if (o_irq !== e[0]) begin failures++; $display("FAIL rise_irq_c%0d got=%b want=%b", c, o_irq, e[0]); end
    end
  endtask

  task automatic test_w1c();
    logic [31:0] d, e, pre;
    logic v, wv;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'h8);
    wr(A_PEND, 32'h8, 4'b0010, 1'b0, wv, pre);
    e = exp_q.pop_front(); checks++;
    if (wv !== e[0]) begin failures++; $display("FAIL w1c_wr_valid got=%b want=%b", wv, e[0]); end
    rd(A_PEND, d, v);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL w1c_wrong_lane got=%h want=%h", d, e); end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    wr(A_PEND, 32'h8, 4'b0001, 1'b0, wv, pre);
    rd(A_PEND, d, v);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL w1c_clear got=%h want=%h", d, e); end
    e = exp_q.pop_front(); checks++;
    if (o_irq !== e[0]) begin failures++; $display("FAIL w1c_irq_same got=%b want=%b", o_irq, e[0]); end
    @(posedge clk); #1;
    e = exp_q.pop_front(); checks++;
    if (o_irq !== e[0]) begin failures++; $display("FAIL w1c_irq_next got=%b want=%b", o_irq, e[0]); end
  endtask

  task automatic test_set_priority();
    logic [31:0] d, e, pre;
    logic v, wv;
    wr(A_FALL, 32'h1, 4'hF, 1'b0, wv, pre);
    @(negedge clk);
    gpi_data[0] = 1'b1;
    repeat (6) @(negedge clk);
    exp_q.push_back(32'h0);
    rd(A_PEND, d, v);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL prio_no_rise got=%h want=%h", d, e); end
    @(negedge clk);
    gpi_data[0] = 1'b0;
    repeat (3) @(posedge clk);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    wr(A_PEND, 32'h1, 4'b0001, 1'b0, wv, pre);
    rd(A_PEND, d, v);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL prio_set_wins got=%h want=%h", d, e); end
    wr(A_PEND, 32'h1, 4'b0001, 1'b0, wv, pre);
    rd(A_PEND, d, v);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL prio_later_clear got=%h want=%h", d, e); end
  endtask

  task automatic test_decode();
    logic [31:0] d, e, pre;
    logic v, wv;
    logic [31:0] addrs [2];
    addrs[0] = BASE + 32'h18;
    addrs[1] = BASE - 32'h4;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(32'h0);
      exp_q.push_back(32'd0);
    end
    for (int k = 0; k < 2; k++) begin
      rd(addrs[k], d, v);
      e = exp_q.pop_front(); checks++;
      if (d !== e) begin failures++; $display("FAIL decode_data%0d got=%h want=%h", k, d, e); end
      e = exp_q.pop_front(); checks++;
      if (v !== e[0]) begin failures++; $display("FAIL decode_rvalid%0d got=%b want=%b", k, v, e[0]); end
    end
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    wr(A_LEVEL, 32'hFFFF_FFFF, 4'hF, 1'b0, wv, pre);
    e = exp_q.pop_front(); checks++;
    if (wv !== e[0]) begin failures++; $display("FAIL level_wr_valid got=%b want=%b", wv, e[0]); end
    wr(BASE + 32'h18, 32'hFFFF_FFFF, 4'hF, 1'b0, wv, pre);
    e = exp_q.pop_front(); checks++;
    if (wv !== e[0]) begin failures++; $display("FAIL oob_wr_valid got=%b want=%b", wv, e[0]); end
  endtask

`ifdef GPI_IRQ_DEBOUNCE_EN
  task automatic test_debounce();
    logic [31:0] d, e, pre;
    logic v, wv;
    wr(A_RISE, 32'h2, 4'hF, 1'b0, wv, pre);
    wr(A_DB, 32'h4, 4'hF, 1'b0, wv, pre);
    @(negedge clk);
    gpi_data[1] = 1'b1;
    repeat (4) @(negedge clk);
    gpi_data[1] = 1'b0;
    repeat (12) @(negedge clk);
    exp_q.push_back(32'(gpi_data));
    exp_q.push_back(32'h0);
    rd(A_LEVEL, d, v);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL db_glitch_level got=%h want=%h", d, e); end
    rd(A_PEND, d, v);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL db_glitch_pending got=%h want=%h", d, e); end
    @(negedge clk);
    gpi_data[1] = 1'b1;
    exp_q.push_back(32'(gpi_data));
    exp_q.push_back(32'h2);
    repeat (5) @(negedge clk);
    gpi_data[1] = 1'b0;
    repeat (4) @(negedge clk);
    rd(A_LEVEL, d, v);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL db_pulse_level got=%h want=%h", d, e); end
    rd(A_PEND, d, v);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL db_pulse_pending got=%h want=%h", d, e); end
    repeat (10) @(negedge clk);
    wr(A_PEND, 32'hFFFF_FFFF, 4'hF, 1'b0, wv, pre);
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] d, e, pre, pat;
    logic v, wv;
    wr(A_RISE, 32'hFF, 4'hF, 1'b0, wv, pre);
    wr(A_FALL, 32'hFF, 4'hF, 1'b0, wv, pre);
    wr(A_IRQEN, 32'hFF, 4'hF, 1'b0, wv, pre);
    @(negedge clk);
    gpi_data[7:0] = ~gpi_data[7:0];
    exp_q.push_back(32'hFF);
    exp_q.push_back(32'd1);
    repeat (14) @(negedge clk);
    rd(A_PEND, d, v);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL pre_reset_pending got=%h want=%h", d, e); end
    e = exp_q.pop_front(); checks++;
    if (o_irq !== e[0]) begin failures++; $display("FAIL pre_reset_irq got=%b want=%b", o_irq, e[0]); end
    gpi_data[7:0] = ~gpi_data[7:0];
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    exp_q.push_back(32'd0);
    for (int k = 0; k < 6; k++) exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (o_irq !== e[0]) begin failures++; $display("FAIL mid_reset_irq got=%b want=%b", o_irq, e[0]); end
    for (int k = 0; k < 6; k++) begin
      rd(BASE + 32'(4 * k), d, v);
      e = exp_q.pop_front(); checks++;
      if (d !== e) begin failures++; $display("FAIL mid_reset_reg%0d got=%h want=%h", k, d, e); end
    end
    pat = 32'h5A5A_C3C3;
    gpi_data = pat;
    @(negedge clk); #2 rst = 1'b1;
    wr(A_RISE, 32'hFFFF_FFFF, 4'hF, 1'b0, wv, pre);
    wr(A_FALL, 32'hFFFF_FFFF, 4'hF, 1'b0, wv, pre);
    exp_q.push_back(32'h0);
    exp_q.push_back(pat);
    exp_q.push_back(32'd0);
    repeat (8) @(negedge clk);
    rd(A_PEND, d, v);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL post_release_pending got=%h want=%h", d, e); end
    rd(A_LEVEL, d, v);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL post_release_level got=%h want=%h", d, e); end
    e = exp_q.pop_front(); checks++;
    if (o_irq !== e[0]) begin failures++; $display("FAIL post_release_irq got=%b want=%b", o_irq, e[0]); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time_limit got=expired want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rw_regs();
    test_rise_irq();
    test_w1c();
    test_set_priority();
    test_decode();
`ifdef GPI_IRQ_DEBOUNCE_EN
    test_debounce();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
